rx_frame_sequencer: RTL and testbench
=====================================

# rx_frame_sequencer

Controller between the serial frame receiver and downstream logic. Watches the receiver's completion and error flags and classifies each finished frame. Good frames go into a two-slot frame buffer; bad frames are dropped and counted. After every frame it re-arms the receiver, applies baud-rate changes only while the receiver is idle, and streams buffered frames out byte by byte over a valid/ready handshake.

## Interface
- BAUD_DEFAULT, 8'd16, baudrate value driven after reset
- clk  in  1  system clock, all logic on posedge
- reset_n  in  1  synchronous reset, active-low
- rx_dr  in  1  receiver frame-complete pulse, 1 cycle
- rx_busy  in  1  receiver is between start bit and stop bit
- rx_framesize  in  4  byte count of received frame
- rx_framedata  in  128  frame payload; byte k at [127-8k -: 8]
- rx_crce, rx_nf, rx_fe  in  1 each  CRC, noise and framing error flags; valid with rx_dr
- rx_rearm  out  1  1-cycle pulse telling the receiver to return to its start state
- baudrate  out  8  active baud divisor to the receiver
- cfg_baud  in  8  new divisor
- cfg_we  in  1  1-cycle write strobe for cfg_baud
- out_data  out  8  payload byte
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts the byte
- out_last  out  1  final byte of the frame, qualified by out_valid
- frame_ok  out  1  1-cycle pulse when a frame is stored
- frame_bad  out  1  1-cycle pulse when a frame is dropped
- cnt_crc, cnt_noise, cnt_frame, cnt_len, cnt_ovf  out  8 each  saturating error counters

## Operation
Input FSM states: IDLE, CLASSIFY, STORE, DROP, REARM.
- **IDLE.** Go to CLASSIFY on rx_dr. Latch the data, size and flags in that same cycle.
- **CLASSIFY.** Check the latched frame in this priority order; the first match wins and only its counter increments:
  - noise error → cnt_noise
  - framing error → cnt_frame
  - CRC error → cnt_crc
  - framesize == 0 → cnt_len
  - buffer full → cnt_ovf

  Any match goes to DROP. No match goes to STORE.
- **STORE.** Write the latched frame to the slot at the write pointer, toggle the write pointer, pulse frame_ok, go to REARM.
- **DROP.** Pulse frame_bad, go to REARM.
- **REARM.** Pulse rx_rearm, go to IDLE.
- rx_dr while not in IDLE is ignored. The receiver cannot produce one before it is re-armed.

Output FSM states: O_IDLE, O_SEND.
- **O_IDLE.** When occupancy > 0, load the byte index with 0 and go to O_SEND.
- **O_SEND.** out_valid = 1. out_data = byte[index] of the slot at the read pointer. out_last = (index == size-1).
  - On a handshake (out_valid & out_ready), increment the index.
  - On a handshake with out_last: free the slot, toggle the read pointer, return to O_IDLE.
- Occupancy is 0–2, 2 bits wide.
  - A STORE and a slot-free in the same cycle leave occupancy unchanged.
  - The full check in CLASSIFY uses the registered occupancy; a free in that same cycle does not rescue the frame.

Baud configuration:
- cfg_we latches cfg_baud into a pending register and sets a pending flag. A later write before the change is applied overwrites the pending value.
- The change is applied (baudrate ← pending value, flag cleared) in any cycle where the pending flag is set, rx_busy = 0 and the input FSM is in IDLE.
- cfg_we and apply in the same cycle: the new write wins and stays pending.

Counters stop at 8'hFF and do not wrap.

## Timing
Reset values (reset_n = 0 at posedge):
- rx_rearm, out_valid, out_last, frame_ok, frame_bad all 0
- baudrate = BAUD_DEFAULT
- all counters 0
- occupancy 0; read and write pointers 0
- both FSMs idle; pending flag clear

Latency:
- rx_dr in cycle t → frame_ok or frame_bad at t+2 → rx_rearm at t+3.
- Earliest out_valid is t+3 (the cycle after STORE) when the buffer was empty.
- One byte per cycle is possible while out_ready is held high.

Handshake: once out_valid is asserted, out_data and out_last stay stable until the handshake.

Reset mid-frame discards all buffered data, including a partially streamed frame. No out_last is produced for that frame.

## Structure
- Package rx_pkg holds:
  - the input and output state enums
  - the type frame_t: 128-bit data plus 4-bit size
  - the constants SLOTS = 2 and CNT_MAX = 8'hFF
- One sub-module, frame_buf2: the two-slot storage with write/read pointers and occupancy. It exposes push, pop, full, empty and the read-slot frame_t.
- Everything else (both FSMs, counters, baud logic) is in the top module.

## Test plan
- **Good frame.** Size 3, data bytes A1 B2 C3, no flags. Expect frame_ok at t+2 and rx_rearm at t+3, then out_data A1, B2, C3 with out_last only on C3.
- **Flag priority.** rx_dr with nf = 1 and crce = 1. Expect cnt_noise = 1, cnt_crc = 0, frame_bad pulse, nothing output.
- **Overflow.** Hold out_ready = 0 and send three good frames. Expect the first two stored, the third dropped with cnt_ovf = 1. Then release out_ready: exactly two frames stream, in order.
- **Zero size.** framesize = 0. Expect cnt_len = 1 and frame_bad.
- **Baud change.** cfg_we with 8'd52 while rx_busy = 1. Expect baudrate unchanged until the first cycle with rx_busy = 0 and the input FSM in IDLE, then 8'd52.
- **Saturation and reset.** 300 CRC-error frames → cnt_crc = 8'hFF. Then assert reset_n = 0 while streaming → all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and constants for the receive frame sequencer.
package rx_pkg;

  typedef enum logic [2:0] {IDLE, CLASSIFY, STORE, DROP, REARM} in_state_t;
  typedef enum logic       {O_IDLE, O_SEND} out_state_t;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   size;
  } frame_t;

  localparam int         SLOTS   = 2;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // Saturating increment for the error counters.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_buf2.sv
// Two-slot frame store with ping-pong write/read pointers and occupancy.
module frame_buf2 import rx_pkg::*; (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  frame_t wr_frame,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output frame_t rd_frame
);

  frame_t     slot [SLOTS];
  logic       wr_ptr, rd_ptr;
  logic [1:0] occ;

  // Pointer and occupancy bookkeeping; push+pop together leaves occ as is.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: ;
      endcase
    end
  end

  // Payload storage; contents are meaningless once occupancy says so.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= wr_frame;
  end

  assign full     = (occ == 2'(SLOTS));
  assign empty    = (occ == 2'd0);
  assign rd_frame = slot[rd_ptr];

endmodule

// File: rtl/rx_frame_sequencer.sv
// Classifies received frames, buffers good ones, counts bad ones, re-arms
// the receiver, applies deferred baud changes and streams bytes out.
module rx_frame_sequencer import rx_pkg::*; #(
  parameter logic [7:0] BAUD_DEFAULT = 8'd16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         rx_dr,
  input  logic         rx_busy,
  input  logic [3:0]   rx_framesize,
  input  logic [127:0] rx_framedata,
  input  logic         rx_crce,
  input  logic         rx_nf,
  input  logic         rx_fe,
  output logic         rx_rearm,
  output logic [7:0]   baudrate,
  input  logic [7:0]   cfg_baud,
  input  logic         cfg_we,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         frame_ok,
  output logic         frame_bad,
  output logic [7:0]   cnt_crc,
  output logic [7:0]   cnt_noise,
  output logic [7:0]   cnt_frame,
  output logic [7:0]   cnt_len,
  output logic [7:0]   cnt_ovf
);

  in_state_t  st, st_nx;
  out_state_t ost, ost_nx;
  frame_t     lat, rd_frame;
  logic       lat_crce, lat_nf, lat_fe;
  logic       push, pop, full, empty, hs;
  logic [3:0] idx;
  logic       pend;
  logic [7:0] pend_baud;

  frame_buf2 u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .wr_frame (lat),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .rd_frame (rd_frame)
  );

  // State registers for both FSMs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st  <= IDLE;
      ost <= O_IDLE;
    end else begin
      st  <= st_nx;
      ost <= ost_nx;
    end
  end

  // Input FSM: classify, then store or drop, then re-arm the receiver.
  always_comb begin
    st_nx     = st;
    push      = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    rx_rearm  = 1'b0;
    case (st)
      IDLE:     if (rx_dr) st_nx = CLASSIFY;
      CLASSIFY: st_nx = (lat_nf || lat_fe || lat_crce || lat.size == 4'd0 || full)
                        ? DROP : STORE;
      STORE: begin
        push     = 1'b1;
        frame_ok = 1'b1;
        st_nx    = REARM;
      end
      DROP: begin
        frame_bad = 1'b1;
        st_nx     = REARM;
      end
      REARM: begin
        rx_rearm = 1'b1;
        st_nx    = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  // Capture the frame in the cycle rx_dr is seen; later pulses are ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat      <= '0;
      lat_crce <= 1'b0;
      lat_nf   <= 1'b0;
      lat_fe   <= 1'b0;
    end else if (st == IDLE && rx_dr) begin
      lat      <= '{data: rx_framedata, size: rx_framesize};
      lat_crce <= rx_crce;
      lat_nf   <= rx_nf;
      lat_fe   <= rx_fe;
    end
  end

  // Error counters: only the highest-priority cause of a drop is counted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_crc   <= 8'd0;
      cnt_noise <= 8'd0;
      cnt_frame <= 8'd0;
      cnt_len   <= 8'd0;
      cnt_ovf   <= 8'd0;
    end else if (st == CLASSIFY) begin
      if      (lat_nf)             cnt_noise <= sat_inc(cnt_noise);
      else if (lat_fe)             cnt_frame <= sat_inc(cnt_frame);
      else if (lat_crce)           cnt_crc   <= sat_inc(cnt_crc);
      else if (lat.size == 4'd0)   cnt_len   <= sat_inc(cnt_len);
      else if (full)               cnt_ovf   <= sat_inc(cnt_ovf);
    end
  end

  // Output FSM. Leaving O_IDLE on push as well as on non-empty lets the
  // first byte appear the cycle after STORE instead of one cycle later.
  always_comb begin
    ost_nx = ost;
    case (ost)
      O_IDLE:  if (!empty || push) ost_nx = O_SEND;
      O_SEND:  if (pop) ost_nx = O_IDLE;
      default: ost_nx = O_IDLE;
    endcase
  end

  assign out_valid = (ost == O_SEND);
  assign hs        = out_valid && out_ready;
  assign out_last  = out_valid && (idx == rd_frame.size - 4'd1);
  assign pop       = hs && out_last;
  // Byte k sits at [127-8k -: 8]; 127-8k == {~k, 3'b111} for a 4-bit k.
  assign out_data  = rd_frame.data[{~idx, 3'b111} -: 8];

  // Byte index within the frame being streamed.
  always_ff @(posedge clk) begin
    if (!reset_n)           idx <= 4'd0;
    else if (ost == O_IDLE) idx <= 4'd0;
    else if (hs)            idx <= idx + 4'd1;
  end

  // Deferred baud change: only applied while the receiver is quiet.
  // A write colliding with an apply keeps the new value pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      baudrate  <= BAUD_DEFAULT;
      pend      <= 1'b0;
      pend_baud <= 8'd0;
    end else begin
      if (pend && !rx_busy && st == IDLE) begin
        baudrate <= pend_baud;
        pend     <= 1'b0;
      end
      if (cfg_we) begin
        pend_baud <= cfg_baud;
        pend      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Scoreboard bench: the driver predicts each frame's fate from the
// classification rules and queues expected bytes; a monitor consumes them.
module tb_rx_frame_sequencer;

  logic         clk, reset_n;
  logic         rx_dr, rx_busy, rx_crce, rx_nf, rx_fe;
  logic [3:0]   rx_framesize;
  logic [127:0] rx_framedata;
  logic         rx_rearm;
  logic [7:0]   baudrate, cfg_baud;
  logic         cfg_we;
  logic [7:0]   out_data;
  logic         out_valid, out_ready, out_last;
  logic         frame_ok, frame_bad;
  logic [7:0]   cnt_crc, cnt_noise, cnt_frame, cnt_len, cnt_ovf;

  rx_frame_sequencer #(.BAUD_DEFAULT(8'd16)) dut (
    .clk(clk), .reset_n(reset_n), .rx_dr(rx_dr), .rx_busy(rx_busy),
    .rx_framesize(rx_framesize), .rx_framedata(rx_framedata),
    .rx_crce(rx_crce), .rx_nf(rx_nf), .rx_fe(rx_fe), .rx_rearm(rx_rearm),
    .baudrate(baudrate), .cfg_baud(cfg_baud), .cfg_we(cfg_we),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_bad(frame_bad),
    .cnt_crc(cnt_crc), .cnt_noise(cnt_noise), .cnt_frame(cnt_frame),
    .cnt_len(cnt_len), .cnt_ovf(cnt_ovf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0, n_errors = 0;
  logic [8:0] exp_q[$];          // {last, byte}
  int stored = 0, popped = 0;    // frames accepted / fully streamed
  int m_crc = 0, m_noise = 0, m_frame = 0, m_len = 0, m_ovf = 0;
  int rdy_mode = 0;              // 0 hold low, 1 hold high, 2 random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic chk_counters();
    chk("cnt_crc",   32'(cnt_crc),   m_crc);
    chk("cnt_noise", 32'(cnt_noise), m_noise);
    chk("cnt_frame", 32'(cnt_frame), m_frame);
    chk("cnt_len",   32'(cnt_len),   m_len);
    chk("cnt_ovf",   32'(cnt_ovf),   m_ovf);
  endtask

  // Consumer readiness, independent of the frame driver.
  initial begin
    out_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 0;
        1:       out_ready = 1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks every accepted byte against the queue and checks that
  // a stalled byte stays put until accepted.
  logic       hold_vld = 0;
  logic [7:0] hold_data;
  logic       hold_last;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset_n) hold_vld = 0;
    else begin
      if (hold_vld) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data",  32'(out_data),  32'(hold_data));
        chk("hold_last",  32'(out_last),  32'(hold_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_byte: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e[7:0]));
          chk("out_last", 32'(out_last), 32'(e[8]));
          if (e[8]) popped++;
        end
      end
      hold_vld  = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  // Drive one frame starting in an IDLE cycle, predict its fate and check
  // the frame_ok/frame_bad and rx_rearm timing. Returns in cycle t+3.
  task automatic send_frame(input logic [3:0] sz, input logic [127:0] d,
                            input logic c, input logic n, input logic f);
    int  occ;
    bit  keep;
    @(posedge clk); #1;                           // cycle t
    rx_dr = 1; rx_framesize = sz; rx_framedata = d;
    rx_crce = c; rx_nf = n; rx_fe = f;
    @(posedge clk); #1;                           // cycle t+1: classify
    rx_dr = 1'($urandom_range(0, 1));             // must be ignored
    rx_framedata = {$urandom, $urandom, $urandom, $urandom};
    rx_framesize = 4'($urandom); rx_crce = 0; rx_nf = 0; rx_fe = 0;
    occ  = stored - popped;
    keep = 0;
    if      (n)        m_noise = sat(m_noise);
    else if (f)        m_frame = sat(m_frame);
    else if (c)        m_crc   = sat(m_crc);
    else if (sz == 0)  m_len   = sat(m_len);
    else if (occ >= 2) m_ovf   = sat(m_ovf);
    else keep = 1;
    if (keep) begin
      stored++;
      for (int k = 0; k < int'(sz); k++)
        exp_q.push_back({k == int'(sz) - 1, d[127 - 8*k -: 8]});
    end
    @(posedge clk); #1;                           // cycle t+2
    rx_dr = 1'($urandom_range(0, 1));
    chk("frame_ok",  32'(frame_ok),  32'(keep));
    chk("frame_bad", 32'(frame_bad), 32'(!keep));
    chk("rearm_early", 32'(rx_rearm), 0);
    @(posedge clk); #1;                           // cycle t+3
    rx_dr = 0;
    chk("rx_rearm", 32'(rx_rearm), 1);
    chk_counters();
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout: got %0d bytes left expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1 chk({name, "_idle"}, 32'(out_valid), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rearm", 32'(rx_rearm), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last",  32'(out_last), 0);
    chk("rst_ok",    32'(frame_ok), 0);
    chk("rst_bad",   32'(frame_bad), 0);
    chk("rst_baud",  32'(baudrate), 16);
    chk_counters();
  endtask

  initial begin
    logic [127:0] d;
    reset_n = 0; rx_dr = 0; rx_busy = 0; rx_framesize = 0; rx_framedata = 0;
    rx_crce = 0; rx_nf = 0; rx_fe = 0; cfg_baud = 0; cfg_we = 0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs();
    reset_n = 1;

    // Good frame A1 B2 C3, streamed as soon as it is stored.
    rdy_mode = 1;
    d = '0; d[127:104] = 24'hA1B2C3;
    send_frame(4'd3, d, 0, 0, 0);
    chk("first_valid", 32'(out_valid), 1);
    chk("first_byte",  32'(out_data), 32'hA1);
    drain("good");

    // Noise outranks CRC.
    send_frame(4'd3, {4{$urandom}}, 1, 1, 0);
    chk("prio_noise", 32'(cnt_noise), 1);
    chk("prio_crc",   32'(cnt_crc), 0);
    repeat (3) @(posedge clk);
    #1 chk("prio_no_out", 32'(out_valid), 0);

    // Overflow: consumer stalled, third frame dropped.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++)
      send_frame(4'($urandom_range(1, 15)), {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
    chk("ovf_count", 32'(cnt_ovf), 1);
    chk("ovf_queued_frames", 32'(stored - popped), 2);
    rdy_mode = 1;
    drain("ovf");

    // Zero-length frame.
    send_frame(4'd0, {4{$urandom}}, 0, 0, 0);
    chk("zero_len", 32'(cnt_len), 1);

    // Baud change held off while the receiver is busy.
    @(posedge clk); #1;
    rx_busy = 1; cfg_we = 1; cfg_baud = 8'd52;
    @(posedge clk); #1;
    cfg_we = 0;
    repeat (3) begin
      chk("baud_held", 32'(baudrate), 16);
      @(posedge clk); #1;
    end
    rx_busy = 0;
    chk("baud_before_apply", 32'(baudrate), 16);
    @(posedge clk); #1;
    chk("baud_applied", 32'(baudrate), 52);
    rx_busy = 1; cfg_we = 1; cfg_baud = 8'd70;
    @(posedge clk); #1;
    cfg_baud = 8'd80;
    @(posedge clk); #1;
    cfg_we = 0; rx_busy = 0;
    @(posedge clk); #1;
    chk("baud_overwrite", 32'(baudrate), 80);

    // Randomised traffic with a random consumer.
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_frame(($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0);
    end
    rdy_mode = 1;
    drain("random");

    // Saturation.
    for (int i = 0; i < 300; i++)
      send_frame(4'($urandom_range(1, 15)), {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0);
    chk("crc_saturated", 32'(cnt_crc), 32'hFF);

    // Reset while a frame is mid-stream.
    send_frame(4'd8, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
    @(posedge clk); #1;
    chk("stream_active", 32'(out_valid), 1);
    reset_n = 0;
    @(posedge clk); #1;
    exp_q.delete(); stored = 0; popped = 0;
    m_crc = 0; m_noise = 0; m_frame = 0; m_len = 0; m_ovf = 0;
    chk_reset_outputs();
    reset_n = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", 32'(out_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
